// File: rtl/mash_pkg.sv
// mash_pkg: shared state encoding, LFSR constants and default width for the MASH sequencer
package mash_pkg;
  localparam int MASH_WIDTH = 16;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FLUSH = 2'd1;
  localparam state_t S_RAMP  = 2'd2;
  localparam state_t S_RUN   = 2'd3;
  // x^16+x^14+x^13+x^11+1 as a right-shifting Galois feedback mask
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
endpackage

// File: rtl/mash_lfsr.sv
// mash_lfsr: 16-bit Galois LFSR with synchronous seed load and advance enable
module mash_lfsr
  import mash_pkg::*;
(
  input  logic        clk,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [15:0] q_o
);
  logic [15:0] q_q, q_d;
  always_comb q_d = load_i ? LFSR_SEED : adv_i ? ({1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_POLY : 16'h0)) : q_q;
  always_ff @(posedge clk) q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/mash_seq_ctrl.sv
// mash_seq_ctrl: MASH chain sequencer with target handshake, flush, slew-limited ramp and lock report
// Define MASH_DITHER_EN to add LFSR dither on frac_out[0] while in RUN.
module mash_seq_ctrl
  import mash_pkg::*;
#(
  parameter int WIDTH     = MASH_WIDTH,
  parameter int STEP      = 256,
  parameter int FLUSH_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_word,
  input  logic             cfg_flush,
  output logic [WIDTH-1:0] frac_out,
  output logic             stage_rst_n,
  output logic             locked
);
  localparam int CW = FLUSH_CYC > 1 ? $clog2(FLUSH_CYC) : 1;
  // Saturate so a huge STEP still fits the WIDTH+1 magnitude compare
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP >= 2**WIDTH ? 2**WIDTH : STEP);
`ifdef MASH_DITHER_EN
  localparam logic [WIDTH-1:0] LOCK_MASK = ~WIDTH'(1);
`else
  localparam logic [WIDTH-1:0] LOCK_MASK = '1;
`endif
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] target_q, target_d, frac_q, frac_d, step;
  logic             ready_q, ready_d, srst_q, srst_d, locked_q, locked_d;
  logic             xfer, near;
  logic [WIDTH:0]   diff, mag;
  assign xfer = cfg_valid & ready_q;
  assign diff = {1'b0, target_q} - {1'b0, frac_q};
  assign mag  = diff[WIDTH] ? -diff : diff;
  assign near = mag <= STEP_W;
  assign step = diff[WIDTH] ? frac_q - STEP_W[WIDTH-1:0] : frac_q + STEP_W[WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_IDLE || (state_q == S_RUN && xfer && cfg_flush)) begin
      state_d = S_FLUSH;
      cnt_d   = CW'(FLUSH_CYC - 1);
    end else if (state_q == S_FLUSH) begin
      state_d = cnt_q == '0 ? S_RAMP : S_FLUSH;
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
    end else if (state_q == S_RAMP && near) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN && xfer) begin
      state_d = S_RAMP;
    end
  end
  always_comb begin
    target_d = xfer ? cfg_word : target_q;
    frac_d   = (state_d == S_IDLE || state_d == S_FLUSH) ? '0 :
               state_q == S_RAMP ? (near ? target_q : step) : frac_q;
    ready_d  = state_d == S_IDLE || state_d == S_RUN;
    srst_d   = state_d == S_RAMP || state_d == S_RUN;
    locked_d = state_d == S_RUN && ((frac_d ^ target_d) & LOCK_MASK) == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q <= '0;
      frac_q   <= '0;
      ready_q  <= 1'b0;
      srst_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      target_q <= target_d;
      frac_q   <= frac_d;
      ready_q  <= ready_d;
      srst_q   <= srst_d;
      locked_q <= locked_d;
    end
  end
  assign cfg_ready   = ready_q;
  assign stage_rst_n = srst_q;
  assign locked      = locked_q;
`ifdef MASH_DITHER_EN
  logic [15:0] lfsr;
  mash_lfsr u_lfsr (
    .clk    (clk),
    .load_i (!rst_n || (state_d == S_FLUSH && state_q != S_FLUSH)),
    .adv_i  (state_q == S_RUN),
    .q_o    (lfsr)
  );
  assign frac_out = frac_q ^ {{(WIDTH-1){1'b0}}, state_q == S_RUN && lfsr[0]};
`else
  assign frac_out = frac_q;
`endif
endmodule

// File: tb/tb_mash_seq_ctrl.sv
// tb_mash_seq_ctrl: table-driven directed check of the MASH sequencer (STEP=256, FLUSH_CYC=4)
module tb_mash_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, enable = 1'b0, cfg_valid = 1'b0, cfg_flush = 1'b0;
  logic [15:0] cfg_word = '0;
  logic        cfg_ready, stage_rst_n, locked;
  logic [15:0] frac_out;
  int          tests = 0, fails = 0;
  typedef struct {
    logic        r, e, v, f;
    logic [15:0] w, fr;
    logic        s, rd, lk;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  mash_seq_ctrl #(.WIDTH(16), .STEP(256), .FLUSH_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_word(cfg_word), .cfg_flush(cfg_flush), .frac_out(frac_out), .stage_rst_n(stage_rst_n),
    .locked(locked)
  );
  function automatic void add(logic r, logic e, logic v, logic f, logic [15:0] w,
                              logic [15:0] fr, logic s, logic rd, logic lk);
    vec_t x;
    x.r = r; x.e = e; x.v = v; x.f = f; x.w = w; x.fr = fr; x.s = s; x.rd = rd; x.lk = lk;
    vq.push_back(x);
  endfunction
  task automatic check(string name, logic [15:0] fr, logic s, logic rd, logic lk);
    tests++;
    if (frac_out !== fr || stage_rst_n !== s || cfg_ready !== rd || locked !== lk) begin
      fails++;
      $display("FAIL %s: got frac=%h srst=%b rdy=%b lk=%b, want frac=%h srst=%b rdy=%b lk=%b",
               name, frac_out, stage_rst_n, cfg_ready, locked, fr, s, rd, lk);
    end
  endtask
  initial begin
    int n;
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    add(1, 0, 0, 0, 16'h0,    16'h0, 0, 1, 0);
    add(1, 0, 1, 0, 16'h1000, 16'h0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    add(1, 1, 0, 0, 16'h0, 16'h0, 1, 0, 0);
    for (int i = 1; i <= 16; i++) add(1, 1, 0, 0, 16'h0, 16'(i * 256), 1, i == 16, i == 16);
    add(1, 1, 0, 0, 16'h0,    16'h1000, 1, 1, 1);
    add(1, 1, 1, 0, 16'h0F80, 16'h1000, 1, 0, 0);
    add(1, 1, 0, 0, 16'h0,    16'h0F80, 1, 1, 1);
    add(1, 1, 1, 1, 16'h8000, 16'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    add(1, 1, 0, 0, 16'h0, 16'h0, 1, 0, 0);
    for (int i = 1; i <= 128; i++) add(1, 1, 0, 0, 16'h0, 16'(i * 256), 1, i == 128, i == 128);
    add(1, 1, 1, 0, 16'h0100, 16'h8000, 1, 0, 0);
    for (int i = 1; i <= 127; i++) add(1, 1, 0, 0, 16'h0, 16'(32768 - i * 256), 1, i == 127, i == 127);
    add(1, 1, 1, 0, 16'h0800, 16'h0100, 1, 0, 0);
    add(1, 1, 0, 0, 16'h0,    16'h0200, 1, 0, 0);
    add(1, 1, 0, 0, 16'h0,    16'h0300, 1, 0, 0);
    add(1, 0, 1, 0, 16'h0200, 16'h0, 0, 1, 0);
    add(1, 1, 1, 0, 16'h0200, 16'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    add(1, 1, 0, 0, 16'h0,    16'h0, 1, 0, 0);
    add(1, 1, 0, 0, 16'h0,    16'h0100, 1, 0, 0);
    add(1, 1, 0, 0, 16'h0,    16'h0200, 1, 1, 1);
    add(1, 1, 1, 0, 16'h0200, 16'h0200, 1, 0, 0);
    add(1, 1, 0, 0, 16'h0,    16'h0200, 1, 1, 1);
    add(1, 0, 0, 0, 16'h0,    16'h0, 0, 1, 0);
    add(1, 1, 0, 0, 16'h0,    16'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    add(1, 1, 0, 0, 16'h0,    16'h0, 1, 0, 0);
    add(1, 1, 0, 0, 16'h0,    16'h0100, 1, 0, 0);
    add(1, 1, 0, 0, 16'h0,    16'h0200, 1, 1, 1);
    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].r; enable = vq[i].e; cfg_valid = vq[i].v; cfg_flush = vq[i].f; cfg_word = vq[i].w;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vq[i].fr, vq[i].s, vq[i].rd, vq[i].lk);
    end
    @(negedge clk); rst_n = 1'b0; enable = 1'b1; cfg_valid = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_run", 16'h0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    check("reset_release", 16'h0, 0, 1, 0);
    @(negedge clk); cfg_valid = 1'b1; cfg_word = 16'h0300;
    @(posedge clk);
    @(negedge clk); cfg_valid = 1'b0; enable = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!locked && n < 30);
    tests++;
    if (n != 8 || !locked) begin
      fails++;
      $display("FAIL lock_latency: got %0d cycles (locked=%b), want 8", n, locked);
    end
    check("lock_value", 16'h0300, 1, 1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
